// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the MixColumns stage.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mixcol_state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column_word.sv
// Combinational single-column MixColumns mixer (32 bits in, 32 bits out).
// With AES_INV_MIXCOL_EN defined, an 'inv' input selects InvMixColumns.
module aes_mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
`ifdef AES_INV_MIXCOL_EN
    input  logic        inv,
`endif
    output logic [31:0] col_out
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [31:0] fwd;

    // Split the column into bytes (a0 is the top byte) and form 2a, 3a.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = col_in[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x3[i] = x2[i] ^ a[i];
        end
    end

    assign fwd = {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
                  a[0]  ^ x2[1] ^ x3[2] ^ a[3],
                  a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
                  x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

`ifdef AES_INV_MIXCOL_EN
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] rev;

    // Inverse coefficients 9/11/13/14 from chained doublings.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
    end

    assign rev = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                  m9[0] ^ me[1] ^ mb[2] ^ md[3],
                  md[0] ^ m9[1] ^ me[2] ^ mb[3],
                  mb[0] ^ md[1] ^ m9[2] ^ me[3]};

    assign col_out = inv ? rev : fwd;
`else
    assign col_out = fwd;
`endif

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Column-serial AES MixColumns: one 32-bit column per clock, four clocks
// per state, valid/ready on both sides. Define AES_INV_MIXCOL_EN to add
// the in_inv port and the InvMixColumns path.
module aes_mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef AES_INV_MIXCOL_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    mixcol_state_e st_q;
    logic [1:0]    col_cnt;
    aes_state_t    work_q;
    aes_state_t    res_q;
    aes_word_t     mix_in;
    aes_word_t     mix_out;
    logic          inv_q;

    // Column mux: pick the column currently being mixed.
    always_comb begin
        mix_in = work_q[127:96];
        case (col_cnt)
            2'd0: mix_in = work_q[127:96];
            2'd1: mix_in = work_q[95:64];
            2'd2: mix_in = work_q[63:32];
            2'd3: mix_in = work_q[31:0];
            default: mix_in = work_q[127:96];
        endcase
    end

    // One mixer shared by all four columns.
    aes_mix_column_word u_mix (
        .col_in  (mix_in),
`ifdef AES_INV_MIXCOL_EN
        .inv     (inv_q),
`endif
        .col_out (mix_out)
    );

    // Control FSM with registered handshake outputs, work/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            col_cnt   <= 2'd0;
            work_q    <= '0;
            res_q     <= '0;
            inv_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q   <= in_state;
`ifdef AES_INV_MIXCOL_EN
                        inv_q    <= in_inv;
`endif
                        col_cnt  <= 2'd0;
                        in_ready <= 1'b0;
                        st_q     <= BUSY;
                    end
                end
                BUSY: begin
                    case (col_cnt)
                        2'd0: res_q[127:96] <= mix_out;
                        2'd1: res_q[95:64]  <= mix_out;
                        2'd2: res_q[63:32]  <= mix_out;
                        default: res_q[31:0] <= mix_out;
                    endcase
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        out_valid <= 1'b1;
                        st_q      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        st_q      <= IDLE;
                    end
                end
                default: begin
                    st_q      <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_state = res_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench for aes_mix_columns_seq: directed known-answer
// vectors, random states against a GF(2^8) matrix model, back-pressure
// and mid-operation reset.
module tb_aes_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef AES_INV_MIXCOL_EN
    logic         in_inv;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    aes_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef AES_INV_MIXCOL_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply by shift-and-add with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product applied to each of the four columns.
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] b [16];
        logic [7:0] r;
        logic [127:0] o = '0;
        if (inv) begin
            coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
        end else begin
            coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
        end
        for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++)
                    r = r ^ gmul(coef[(j - i + 4) % 4], b[4*c + j]);
                o[127-8*(4*c+i) -: 8] = r;
            end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a state, wait for out_valid, check latency/result, handshake.
    task automatic run(input string tag, input logic [127:0] s, input logic inv,
                       input logic [127:0] exp);
        int lat;
        chk({tag, "_in_ready_idle"}, {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_state = s;
`ifdef AES_INV_MIXCOL_EN
        in_inv   = inv;
`endif
        tick();
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_in_ready_busy"}, {127'd0, in_ready}, 128'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, out_state, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_released"}, {126'd0, in_ready, out_valid}, 128'b10);
    endtask

    initial begin
        logic [127:0] s, held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
`ifdef AES_INV_MIXCOL_EN
        in_inv    = 1'b0;
`endif
        #12;
        chk("reset_ready", {127'd0, in_ready}, 128'd1);
        chk("reset_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_state", out_state, 128'd0);
        rst_n = 1'b1;
        tick();

        // Known-answer vectors.
        run("kat1", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        run("kat2", 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
            128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);

        // out_ready while idle is ignored.
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("idle_oready", {126'd0, in_ready, out_valid}, 128'b10);

        // Random states against the model.
        for (int i = 0; i < 8; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run("rand", s, 1'b0, model(s, 1'b0));
        end

        // Back-pressure: result stays put, no second accept.
        s = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        in_state = s;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("bp_valid", {127'd0, out_valid}, 128'd1);
        held = model(s, 1'b0);
        chk("bp_data", out_state, held);
        for (int i = 0; i < 10; i++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_hold", {out_state, 1'b0}, {held, 1'b0});
            chk("bp_flags", {126'd0, in_ready, out_valid}, 128'b01);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {126'd0, in_ready, out_valid}, 128'b10);

        // Reset in the middle of a state (col_cnt == 2).
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {126'd0, in_ready, out_valid}, 128'b10);
        chk("midrst_state", out_state, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        s = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        run("after_rst", s, 1'b0, model(s, 1'b0));

`ifdef AES_INV_MIXCOL_EN
        run("inv_kat", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
            128'hdb135345_f20a225c_01010101_c6c6c6c6);
        for (int i = 0; i < 4; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run("inv_rand", s, 1'b1, model(s, 1'b1));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
